// File: rtl/pipe_mem_ctrl_pkg.sv
// pipe_mem_ctrl_pkg
// Common pipeline definitions shared by the memory-stage controller and its
// hazard logic: the memory FSM state encoding and the wait-timeout limit.
package pipe_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int unsigned WAIT_W = 4;

  // Number of unacknowledged BUSY cycles after which the access is abandoned.
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = 4'd15;
  // Counter value seen in the last BUSY cycle before the timeout fires.
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_LIMIT - 4'd1;

endpackage

// File: rtl/pipe_mem_ctrl_hazard_unit.sv
// hazard_unit
// Combinational pipeline hazard resolution.
//   rmem_ex, wreg_ex, rw_ex : EX-stage instruction is a load writing rw_ex
//   rs_id, rt_id, use_*_id  : ID-stage source registers and whether they are read
//   branch_ex               : taken branch/jump resolved in EX
//   freeze                  : memory stall, holds the whole pipeline
//   stall_id, bubble_ex     : load-use interlock (hold ID, inject EX bubble)
//   flush_id                : squash the wrong-path instruction in ID
// Priority is freeze > flush > load-use.
module hazard_unit (
  input  logic       rmem_ex,
  input  logic       wreg_ex,
  input  logic [4:0] rw_ex,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rs_id,
  input  logic       use_rt_id,
  input  logic       branch_ex,
  input  logic       freeze,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       flush_id
);

  logic load_use;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = rmem_ex & wreg_ex & (rw_ex != 5'd0) &
                    ((use_rs_id & (rs_id == rw_ex)) |
                     (use_rt_id & (rt_id == rw_ex)));

  // A taken branch squashes ID anyway, so the interlock is pointless then.
  assign flush_id  = branch_ex & ~freeze;
  assign stall_id  = load_use & ~freeze & ~branch_ex;
  assign bubble_ex = stall_id;

endmodule

// File: rtl/pipe_mem_ctrl.sv
// pipe_mem_ctrl
// ME-stage data-memory controller with pipeline freeze and hazard outputs.
//   clock, reset_0          : rising-edge clock, asynchronous active-low reset
//   rmem_me, wmem_me        : ME-stage load / store request (store wins if both)
//   ans_me, b_me            : ME-stage byte address and store data
//   mem_req/we/addr/wdata   : request to data memory (held while BUSY)
//   mem_ack, mem_rdata      : completion pulse and load data from memory
//   ld_data                 : registered load result towards WB
//   freeze                  : hold PC and all stage registers
//   mem_err                 : sticky timeout flag
//   EX/ID hazard inputs and stall_id, bubble_ex, flush_id via hazard_unit
module pipe_mem_ctrl
  import pipe_mem_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset_0,
  input  logic        rmem_me,
  input  logic        wmem_me,
  input  logic [31:0] ans_me,
  input  logic [31:0] b_me,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        freeze,
  input  logic        rmem_ex,
  input  logic        wreg_ex,
  input  logic [4:0]  rw_ex,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        use_rs_id,
  input  logic        use_rt_id,
  input  logic        branch_ex,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic        mem_err
);

  mem_state_e        state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [31:0]       ld_data_q;
  logic              mem_err_q;
  logic              access_pend;
  logic              active;

  assign access_pend = rmem_me | wmem_me;

  always_ff @(posedge clock or negedge reset_0) begin
    if (!reset_0) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      ld_data_q  <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (access_pend) begin
            state_q    <= ST_BUSY;
            wait_cnt_q <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ack) begin
            if (rmem_me && !wmem_me) begin
              ld_data_q <= mem_rdata;
            end
            state_q <= ST_DONE;
          end else if (wait_cnt_q == WAIT_LAST) begin
            // Memory never answered: give up, report, and return a clean zero.
            wait_cnt_q <= WAIT_LIMIT;
            mem_err_q  <= 1'b1;
            ld_data_q  <= '0;
            state_q    <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        // One cycle with freeze low lets the pipeline advance past the access
        // before a new request can be recognised.
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign active = ((state_q == ST_IDLE) & access_pend) | (state_q == ST_BUSY);

  // The request is dropped the instant reset is asserted, not at the next edge.
  assign mem_req = reset_0 & active;
  assign freeze  = active;

  // The ME stage registers are frozen during the access, so the request
  // fields can be driven straight from them and remain stable while BUSY.
  assign mem_we    = wmem_me;
  assign mem_addr  = ans_me;
  assign mem_wdata = b_me;
  assign ld_data   = ld_data_q;
  assign mem_err   = mem_err_q;

  hazard_unit u_hazard (
    .rmem_ex   (rmem_ex),
    .wreg_ex   (wreg_ex),
    .rw_ex     (rw_ex),
    .rs_id     (rs_id),
    .rt_id     (rt_id),
    .use_rs_id (use_rs_id),
    .use_rt_id (use_rt_id),
    .branch_ex (branch_ex),
    .freeze    (freeze),
    .stall_id  (stall_id),
    .bubble_ex (bubble_ex),
    .flush_id  (flush_id)
  );

endmodule

// File: tb/tb_pipe_mem_ctrl.sv
module tb_pipe_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset_0;
  logic        rmem_me, wmem_me;
  logic [31:0] ans_me, b_me;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ld_data;
  logic        freeze;
  logic        rmem_ex, wreg_ex;
  logic [4:0]  rw_ex, rs_id, rt_id;
  logic        use_rs_id, use_rt_id, branch_ex;
  logic        stall_id, bubble_ex, flush_id;
  logic        mem_err;

  // Model of the expected outputs for the current cycle.
  logic        exp_req, exp_frz, exp_err;
  logic [31:0] exp_ld;
  logic        chk_en, chk_full;
  int          total, bad, frz_seen;
  logic        we_seen;
  logic [31:0] wdata_seen;

  always #5 clock = ~clock;

  pipe_mem_ctrl dut (
    .clock(clock), .reset_0(reset_0),
    .rmem_me(rmem_me), .wmem_me(wmem_me), .ans_me(ans_me), .b_me(b_me),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ld_data(ld_data), .freeze(freeze),
    .rmem_ex(rmem_ex), .wreg_ex(wreg_ex), .rw_ex(rw_ex), .rs_id(rs_id), .rt_id(rt_id),
    .use_rs_id(use_rs_id), .use_rt_id(use_rt_id), .branch_ex(branch_ex),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id), .mem_err(mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      logic lu;
      chk("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      chk("ld_data", ld_data, exp_ld);
      chk("mem_err", {31'd0, mem_err}, {31'd0, exp_err});
      if (chk_full) begin
        lu = rmem_ex && wreg_ex && rw_ex != 0 &&
             ((use_rs_id && rs_id == rw_ex) || (use_rt_id && rt_id == rw_ex));
        chk("freeze", {31'd0, freeze}, {31'd0, exp_frz});
        chk("flush_id", {31'd0, flush_id}, {31'd0, branch_ex && !exp_frz});
        chk("stall_id", {31'd0, stall_id}, {31'd0, lu && !exp_frz && !branch_ex});
        chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, lu && !exp_frz && !branch_ex});
      end
      if (exp_req) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, wmem_me});
        chk("mem_addr", mem_addr, ans_me);
        chk("mem_wdata", mem_wdata, b_me);
      end
      if (freeze === 1'b1) frz_seen++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_hazard();
    rmem_ex   = 1'($urandom % 2);
    wreg_ex   = 1'($urandom % 2);
    rw_ex     = 5'($urandom_range(0, 3));
    rs_id     = 5'($urandom_range(0, 3));
    rt_id     = 5'($urandom_range(0, 3));
    use_rs_id = 1'($urandom % 2);
    use_rt_id = 1'($urandom % 2);
    branch_ex = ($urandom % 4) == 0;
  endtask

  task automatic set_load_use(input logic [4:0] rw, input logic br);
    rmem_ex = 1; wreg_ex = 1; rw_ex = rw; rs_id = 5'd5; use_rs_id = 1;
    rt_id = 5'd0; use_rt_id = 0; branch_ex = br;
  endtask

  task automatic idle_cycle();
    step();
    rmem_me = 0; wmem_me = 0;
    ans_me = $urandom; b_me = $urandom;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    rand_hazard();
    exp_req = 0; exp_frz = 0;
  endtask

  // One access whose ack arrives after d empty BUSY cycles (d >= 15: never).
  task automatic do_access(input logic ld, input logic st, input logic [31:0] addr,
                           input logic [31:0] data, input int d,
                           input logic [31:0] rdata, input bit hz_force);
    int nb;
    nb = (d < 15) ? d + 1 : 15;
    $display("access ld=%0d st=%0d addr=%h wdata=%h wait=%0d rdata=%h",
             ld, st, addr, data, d, rdata);
    step();
    rmem_me = ld; wmem_me = st; ans_me = addr; b_me = data;
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    rand_hazard();
    if (hz_force) set_load_use(5'd5, 1'b1);
    exp_req = 1; exp_frz = 1;
    #1;
    we_seen = mem_we; wdata_seen = mem_wdata;
    if (hz_force) begin
      chk("frz_flush", {31'd0, flush_id}, 32'd0);
      chk("frz_stall", {31'd0, stall_id}, 32'd0);
      chk("frz_bubble", {31'd0, bubble_ex}, 32'd0);
    end
    for (int i = 1; i <= nb; i++) begin
      step();
      mem_ack = (d < 15) && (i == d + 1);
      mem_rdata = mem_ack ? rdata : $urandom;
      rand_hazard();
    end
    step();
    if (d >= 15) begin
      exp_ld = 0; exp_err = 1;
    end else if (ld && !st) begin
      exp_ld = rdata;
    end
    mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    rand_hazard();
    exp_req = 0; exp_frz = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; frz_seen = 0;
    chk_en = 0; chk_full = 1;
    exp_req = 0; exp_frz = 0; exp_err = 0; exp_ld = 0;
    reset_0 = 0; rmem_me = 0; wmem_me = 0; ans_me = 0; b_me = 0;
    mem_ack = 0; mem_rdata = 0;
    rmem_ex = 0; wreg_ex = 0; rw_ex = 0; rs_id = 0; rt_id = 0;
    use_rs_id = 0; use_rt_id = 0; branch_ex = 0;
    repeat (3) @(posedge clock);
    #1 reset_0 = 1;
    chk_en = 1;
    #1;
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_stall", {31'd0, stall_id}, 32'd0);
    chk("rst_bubble", {31'd0, bubble_ex}, 32'd0);
    chk("rst_flush", {31'd0, flush_id}, 32'd0);
    chk("rst_ld", ld_data, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);

    // Load with ack on the 3rd BUSY cycle.
    idle_cycle();
    frz_seen = 0;
    do_access(1, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0);
    #1;
    chk("ld_frz_cycles", frz_seen, 32'd4);
    chk("ld_value", ld_data, 32'hDEADBEEF);
    chk("ld_we", {31'd0, we_seen}, 32'd0);

    // Store with immediate ack.
    idle_cycle();
    frz_seen = 0;
    do_access(0, 1, 32'h200, 32'h12345678, 0, 32'h0, 0);
    #1;
    chk("st_frz_cycles", frz_seen, 32'd2);
    chk("st_we", {31'd0, we_seen}, 32'd1);
    chk("st_wdata", wdata_seen, 32'h12345678);
    chk("st_ld_hold", ld_data, 32'hDEADBEEF);

    // Load-use hazards in an idle cycle.
    idle_cycle();
    set_load_use(5'd5, 1'b0);
    #1;
    chk("lu_stall", {31'd0, stall_id}, 32'd1);
    chk("lu_bubble", {31'd0, bubble_ex}, 32'd1);
    idle_cycle();
    set_load_use(5'd0, 1'b0); rs_id = 5'd0;
    #1;
    chk("lu_r0_stall", {31'd0, stall_id}, 32'd0);
    chk("lu_r0_bubble", {31'd0, bubble_ex}, 32'd0);
    idle_cycle();
    set_load_use(5'd5, 1'b1);
    #1;
    chk("br_flush", {31'd0, flush_id}, 32'd1);
    chk("br_stall", {31'd0, stall_id}, 32'd0);
    // Hazards forced during the freeze of this access.
    do_access(1, 0, 32'h300, 32'h0, 1, 32'hCAFEF00D, 1);

    // Randomized accesses with random idle gaps.
    for (int n = 0; n < 40; n++) begin
      logic ld, st;
      int gap;
      ld = 1'($urandom % 2);
      st = ld ? 1'($urandom % 2) : 1'b1;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle();
      do_access(ld, st, $urandom, $urandom, $urandom_range(0, 6), $urandom, 0);
    end

    // Timeout.
    idle_cycle();
    do_access(1, 0, 32'h400, 32'h0, 15, 32'h0, 0);
    #1;
    chk("to_err", {31'd0, mem_err}, 32'd1);
    chk("to_ld", ld_data, 32'd0);
    chk("to_done_req", {31'd0, mem_req}, 32'd0);
    repeat (20) idle_cycle();
    #1;
    chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

    // Reset in the 2nd BUSY cycle, then a late ack.
    $display("access reset-abort addr=00000500");
    step();
    rmem_me = 1; wmem_me = 0; ans_me = 32'h500; mem_ack = 0; rand_hazard();
    exp_req = 1; exp_frz = 1;
    step();
    mem_ack = 0;
    step();
    reset_0 = 0; chk_full = 0;
    exp_req = 0; exp_ld = 0; exp_err = 0;
    #1;
    chk("rst_busy_req", {31'd0, mem_req}, 32'd0);
    step();
    rmem_me = 0;
    step();
    reset_0 = 1; chk_full = 1; exp_frz = 0;
    mem_ack = 1; mem_rdata = 32'hBADBAD00;
    idle_cycle();
    idle_cycle();
    #1;
    chk("late_ack_ld", ld_data, 32'd0);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    do_access(1, 0, 32'h600, 32'h0, 1, 32'h0BADF00D, 0);
    idle_cycle();
    #1;
    chk("post_rst_ld", ld_data, 32'h0BADF00D);
    idle_cycle();
    @(posedge clock);
    #1;
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
